// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit: op and state encodings plus a
// width-parametrised two's-complement negate/abs used by the sign fixups.
package mdu_pkg;

  localparam int unsigned OpWidth  = 3;
  // Widest datapath the helpers handle; callers truncate the result to their own width.
  localparam int unsigned MaxWidth = 128;

  typedef enum logic [OpWidth-1:0] {
    OpMult  = 3'b000,
    OpMultu = 3'b001,
    OpDiv   = 3'b010,
    OpDivu  = 3'b011,
    OpMthi  = 3'b100,
    OpMtlo  = 3'b101,
    OpNop6  = 3'b110,
    OpNop7  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } state_e;

  function automatic logic [MaxWidth-1:0] cond_neg(input logic [MaxWidth-1:0] x,
                                                   input logic                neg,
                                                   input int unsigned         width);
    logic [MaxWidth-1:0] mask;
    mask = (MaxWidth'(1) << width) - MaxWidth'(1);
    return (neg ? (~x + MaxWidth'(1)) : x) & mask;
  endfunction

  function automatic logic [MaxWidth-1:0] abs_w(input logic [MaxWidth-1:0] x,
                                                input logic                is_signed,
                                                input int unsigned         width);
    return cond_neg(x, is_signed && x[width-1], width);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative datapath: shift-add for multiply (LSB first) or a
// restoring shift-subtract for divide. Quotient bits accumulate in the low half.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] shl;

  always_comb begin
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    shl  = {acc_i, 1'b0};
    // Partial remainder is below the divisor, so after the shift it fits in WIDTH+1 bits.
    diff = shl[2*WIDTH:WIDTH] - {1'b0, opnd_i};
    if (!is_div_i) begin
      if (acc_i[0]) begin
        acc_o = {sum, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
    end else if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      acc_o = shl[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: magnitudes are latched in IDLE,
// iterated one bit per cycle in RUN, and sign-corrected and written back in FIX.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  op_e               op_in;
  logic              signed_op;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [AccW-1:0]   acc_step;
  logic [AccW-1:0]   fix_val;

  assign op_in = op_e'(op);

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(is_div_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (acc_step)
  );

  always_comb begin
    signed_op = (op_in == OpMult) || (op_in == OpDiv);
    a_mag     = WIDTH'(abs_w(MaxWidth'(a), signed_op, WIDTH));
    b_mag     = WIDTH'(abs_w(MaxWidth'(b), signed_op, WIDTH));
  end

  // Remainder follows the dividend's sign, which also reproduces raw a on divide by zero.
  always_comb begin
    fix_val = '0;
    if (is_div_q) begin
      fix_val[WIDTH-1:0]    = div0_q ? '1 :
                              WIDTH'(cond_neg(MaxWidth'(acc_q[WIDTH-1:0]), neg_q, WIDTH));
      fix_val[AccW-1:WIDTH] = WIDTH'(cond_neg(MaxWidth'(acc_q[AccW-1:WIDTH]), neg_rem_q,
                                              WIDTH));
    end else begin
      fix_val = AccW'(cond_neg(MaxWidth'(acc_q), neg_q, AccW));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (op_in)
            OpMult, OpMultu: begin
              state_d   = StRun;
              cnt_d     = '0;
              is_div_d  = 1'b0;
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              opnd_d    = a_mag;
              neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
            end
            OpDiv, OpDivu: begin
              state_d   = StRun;
              cnt_d     = '0;
              is_div_d  = 1'b1;
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opnd_d    = b_mag;
              neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = signed_op && a[WIDTH-1];
              div0_d    = (b == '0);
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        hi_d    = fix_val[AccW-1:WIDTH];
        lo_d    = fix_val[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the combinational ALU in the execute stage and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. Arithmetic is iterative, one bit per cycle, with a start/busy/done handshake so the pipeline can stall on an access to HI/LO.

## Interface
Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits. Must be at least 4.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-op.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  one-cycle pulse when hi/lo take an arithmetic result.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1 and op MULT..DIVU: latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned), and the result sign flags. Go to RUN with counter=0 and busy=1.
- IDLE with start=1 and op MTHI or MTLO: write a to hi or lo on the same edge. Stay in IDLE; busy and done stay low.
- IDLE with start=1 and op 110/111: no effect.
- RUN, multiply: one shift-add step per cycle into a 2*WIDTH accumulator.
- RUN, divide: one restoring shift-subtract step per cycle.
- RUN exit: when counter reaches WIDTH-1, go to FIX.
- FIX, signed multiply: negate the 2*WIDTH product if the operand signs differ.
- FIX, signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- FIX exit: write hi/lo, go to IDLE, assert done for exactly one cycle.
- Divide by zero (DIV or DIVU, b=0): still takes the full latency. Result lo = all ones, hi = a (raw a, no sign fixup).
- Signed overflow: DIV of most-negative by -1 gives lo = most-negative, hi = 0. This falls out of the magnitude datapath with no special case.
- start while busy is ignored: no queueing, no abort, operands not re-latched.
- hi/lo hold their values between ops. A new arithmetic op changes them only at the FIX edge; the pipeline must stall HI/LO readers while busy=1.
- Reset (at any time, including mid-RUN/FIX):
  - state returns to IDLE; busy and done go to 0;
  - hi and lo go to 0; the in-flight op is discarded.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0, state IDLE.
- Arithmetic op with start high in cycle 0:
  - busy is high in cycles 1 through WIDTH+1 (RUN for WIDTH cycles, then FIX);
  - hi/lo are updated and done=1 in cycle WIDTH+2 (34 cycles at WIDTH=32).
- MTHI/MTLO: hi/lo are updated in cycle 1; zero stall.
- A new start is accepted in the same cycle done is high (state is IDLE then).
- done never overlaps busy.
- Products use the full 2*WIDTH width, with no truncation before the split into hi/lo.

## Structure
- Shared package mdu_pkg holds:
  - the op encoding as an enum plus localparams;
  - the state enum (IDLE/RUN/FIX);
  - a two's-complement negate/abs function, parametrised by width.
- One sub-module: mdu_step, the combinational single-iteration datapath (mode select mul/div; inputs accumulator, operand, quotient bits; outputs next values). The FSM, counter and HI/LO registers stay in mul_div_unit.
- Counter width is $clog2(WIDTH).

## Test plan
All cases at WIDTH=32.
- MULT a=FFFFFFFD (-3), b=00000005 -> done in cycle 34; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU a=00000007, b=0 -> done in cycle 34; lo=FFFFFFFF, hi=00000007.
- Combined sequence: MTHI a=12345678 gives hi=12345678 in cycle 1 with busy low; then MULTU 3x4; then start with MTLO while busy, which must have no effect; then assert reset in cycle 10 of a DIV. Required: busy, done, hi and lo all become 0 immediately, and no done pulse follows.
